// File: rtl/vga_scanout.sv
// vga_scanout: parametrised VGA timing generator and VRAM scanout (direct RGB444 or 4bpp palette).
// Defining VGA_PIXEL_DOUBLE_EN scans a half-resolution framebuffer with 2x2 pixel replication.
module vga_scanout #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic        HS_POL   = 1'b0,
  parameter logic        VS_POL   = 1'b0,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned RAM_LAT  = 1
) (
  input  logic              clock,
  input  logic              clear,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] q,
  input  logic [ADDR_W-1:0] base,
  input  logic              mode,
  input  logic              pal_we,
  input  logic [3:0]        pal_idx,
  input  logic [11:0]       pal_rgb,
  output logic [3:0]        VGA_R,
  output logic [3:0]        VGA_G,
  output logic [3:0]        VGA_B,
  output logic              VGA_HS,
  output logic              VGA_VS,
  output logic              frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL + 1);
  localparam int unsigned VW      = $clog2(V_TOTAL + 1);
  localparam int unsigned PW      = ADDR_W + 2;
  localparam int unsigned DLY     = RAM_LAT + 1;

  localparam logic [HW-1:0] HActive = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HsStart = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HsEnd   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] HLast   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] VActive = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VsStart = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VsEnd   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] VLast   = VW'(V_TOTAL - 1);

  typedef struct packed {
    logic       act;
    logic       hs;
    logic       vs;
    logic       fs;
    logic       mode;
    logic [1:0] nib;
  } pipe_t;

  logic [HW-1:0]     h_q, h_d;
  logic [VW-1:0]     v_q, v_d;
  logic [PW-1:0]     p_q, p_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] base_q, base_d, base_eff;
  logic              mode_q, mode_d, mode_eff;
  logic              h_last, v_last, frame0, active;
  pipe_t             pipe_in, st;
  pipe_t             pipe_q [DLY];
  logic [11:0]       pal_q [16];
  logic [3:0]        pix_nib;
  logic [11:0]       rgb_q, rgb_d;
  logic              hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
`ifdef VGA_PIXEL_DOUBLE_EN
  logic [PW-1:0]     line_q, line_d;
`endif

  assign h_last = (h_q == HLast);
  assign v_last = (v_q == VLast);
  assign frame0 = (h_q == '0) && (v_q == '0);
  assign active = (h_q < HActive) && (v_q < VActive);

  // The first pixel of a frame must already use the freshly sampled base/mode.
  assign base_eff = frame0 ? base : base_q;
  assign mode_eff = frame0 ? mode : mode_q;

  always_comb begin
    h_d    = h_last ? '0 : h_q + 1'b1;
    v_d    = v_q;
    if (h_last) v_d = v_last ? '0 : v_q + 1'b1;
    base_d = base_eff;
    mode_d = mode_eff;
    p_d    = p_q;
    addr_d = addr_q;
`ifdef VGA_PIXEL_DOUBLE_EN
    line_d = line_q;
    if (active) begin
      addr_d = base_eff + (mode_eff ? p_q[PW-1:2] : p_q[ADDR_W-1:0]);
      if (h_q[0]) p_d = p_q + 1'b1;
    end
    // Even lines replay their framebuffer row on the following odd line.
    if (h_last && (v_q < VActive)) begin
      if (!v_q[0]) p_d = line_q;
      else         line_d = p_q;
    end
    if (h_last && v_last) begin
      p_d    = '0;
      line_d = '0;
    end
`else
    if (active) begin
      addr_d = base_eff + (mode_eff ? p_q[PW-1:2] : p_q[ADDR_W-1:0]);
      p_d    = p_q + 1'b1;
    end
    if (h_last && v_last) p_d = '0;
`endif
  end

  always_comb begin
    pipe_in      = '0;
    pipe_in.act  = active;
    pipe_in.hs   = (h_q >= HsStart) && (h_q < HsEnd);
    pipe_in.vs   = (v_q >= VsStart) && (v_q < VsEnd);
    pipe_in.fs   = frame0;
    pipe_in.mode = mode_eff;
    pipe_in.nib  = p_q[1:0];
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      h_q    <= '0;
      v_q    <= '0;
      p_q    <= '0;
      addr_q <= '0;
      base_q <= '0;
      mode_q <= 1'b0;
`ifdef VGA_PIXEL_DOUBLE_EN
      line_q <= '0;
`endif
      for (int unsigned i = 0; i < DLY; i++) pipe_q[i] <= '0;
    end else begin
      h_q    <= h_d;
      v_q    <= v_d;
      p_q    <= p_d;
      addr_q <= addr_d;
      base_q <= base_d;
      mode_q <= mode_d;
`ifdef VGA_PIXEL_DOUBLE_EN
      line_q <= line_d;
`endif
      pipe_q[0] <= pipe_in;
      for (int unsigned i = 1; i < DLY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // Combinational read: a same-cycle write is seen by lookups only from the next cycle.
  always_ff @(posedge clock) begin
    if (pal_we) pal_q[pal_idx] <= pal_rgb;
  end

  // The last delay stage lines up with the VRAM data for the same pixel.
  assign st = pipe_q[DLY-1];

  always_comb begin
    case (st.nib)
      2'd0:    pix_nib = q[3:0];
      2'd1:    pix_nib = q[7:4];
      2'd2:    pix_nib = q[11:8];
      default: pix_nib = q[15:12];
    endcase
    rgb_d = '0;
    if (st.act) rgb_d = st.mode ? pal_q[pix_nib] : q[11:0];
    hs_d = st.hs ? HS_POL : ~HS_POL;
    vs_d = st.vs ? VS_POL : ~VS_POL;
    fs_d = st.fs;
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      rgb_q <= '0;
      hs_q  <= ~HS_POL;
      vs_q  <= ~VS_POL;
      fs_q  <= 1'b0;
    end else begin
      rgb_q <= rgb_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      fs_q  <= fs_d;
    end
  end

  assign addr        = addr_q;
  assign VGA_R       = rgb_q[11:8];
  assign VGA_G       = rgb_q[7:4];
  assign VGA_B       = rgb_q[3:0];
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout on a reduced 16x8-clock raster (8x4 visible), one DUT per RAM latency.
module tb_vga_scanout;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clear   = 1'b1;
  logic [15:0] base    = 16'h0000;
  logic        mode    = 1'b0;
  logic        pal_we  = 1'b0;
  logic [3:0]  pal_idx = 4'h0;
  logic [11:0] pal_rgb = 12'h000;

  logic [15:0] addr1, addr2, q1, q2, q2a;
  logic [3:0]  r1, g1, b1, r2, g2, b2;
  logic        hs1, vs1, fs1, hs2, vs2, fs2;

  vga_scanout #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .ADDR_W(16), .DATA_W(16), .RAM_LAT(1)
  ) u_dut1 (
    .clock(clk), .clear(clear), .addr(addr1), .q(q1), .base(base), .mode(mode),
    .pal_we(pal_we), .pal_idx(pal_idx), .pal_rgb(pal_rgb),
    .VGA_R(r1), .VGA_G(g1), .VGA_B(b1), .VGA_HS(hs1), .VGA_VS(vs1), .frame_start(fs1)
  );

  vga_scanout #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .ADDR_W(16), .DATA_W(16), .RAM_LAT(2)
  ) u_dut2 (
    .clock(clk), .clear(clear), .addr(addr2), .q(q2), .base(base), .mode(mode),
    .pal_we(pal_we), .pal_idx(pal_idx), .pal_rgb(pal_rgb),
    .VGA_R(r2), .VGA_G(g2), .VGA_B(b2), .VGA_HS(hs2), .VGA_VS(vs2), .frame_start(fs2)
  );

  // VRAM models: every word holds its own address.
  always @(posedge clk) begin
    q1  <= addr1;
    q2a <= addr2;
    q2  <= q2a;
  end

  // cyc equals the raster index (v*16 + h) the DUT counters hold in the current cycle.
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= clear ? 0 : cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int unsigned idx;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        fs;
    string       name;
  } vec_t;
  vec_t vq[$];

  function automatic logic [15:0] pins1();
    return {1'b0, r1, g1, b1, hs1, vs1, fs1};
  endfunction

  function automatic logic [15:0] pins2();
    return {1'b0, r2, g2, b2, hs2, vs2, fs2};
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic wait_cyc(input int unsigned n);
    int unsigned guard = 0;
    @(negedge clk);
    while (cyc != n && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != n) begin
      checks++;
      errors++;
      $display("FAIL wait_cyc: cyc %0d target %0d", cyc, n);
    end
  endtask

  // Pins for raster index idx appear PIPE = RAM_LAT + 2 cycles later.
  task automatic check_px(input string name, input int unsigned idx, input logic [11:0] rgb,
                          input logic hs, input logic vs, input logic fs);
    wait_cyc(idx + 3);
    check({name, " ram_lat1"}, pins1(), {1'b0, rgb, hs, vs, fs});
    wait_cyc(idx + 4);
    check({name, " ram_lat2"}, pins2(), {1'b0, rgb, hs, vs, fs});
  endtask

  task automatic check_seq4(input string name, input int unsigned idx, input logic [11:0] e0,
                            input logic [11:0] e1, input logic [11:0] e2, input logic [11:0] e3);
    logic [11:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    for (int k = 0; k <= 4; k++) begin
      wait_cyc(idx + 3 + k);
      if (k < 4) check($sformatf("%s x%0d ram_lat1", name, k), {4'h0, r1, g1, b1}, {4'h0, e[k]});
      if (k > 0) check($sformatf("%s x%0d ram_lat2", name, k - 1), {4'h0, r2, g2, b2},
                       {4'h0, e[k-1]});
    end
  endtask

  task automatic add_vec(input int unsigned idx, input logic [11:0] rgb, input logic hs,
                         input logic vs, input logic fs, input string name);
    vec_t v;
    v.idx = idx; v.rgb = rgb; v.hs = hs; v.vs = vs; v.fs = fs; v.name = name;
    vq.push_back(v);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset pins ram_lat1", pins1(), {1'b0, 12'h000, 1'b1, 1'b1, 1'b0});
    check("reset pins ram_lat2", pins2(), {1'b0, 12'h000, 1'b1, 1'b1, 1'b0});
    check("reset addr", addr1, 16'h0000);

    for (int i = 0; i < 16; i++) begin
      pal_we  = 1'b1;
      pal_idx = 4'(i);
      pal_rgb = (i == 5) ? 12'hF0A : {4'(i), ~4'(i), 4'(i) ^ 4'h5};
      @(negedge clk);
    end
    pal_we = 1'b0;
    base   = 16'h1000;
    mode   = 1'b0;
    clear  = 1'b0;

`ifdef VGA_PIXEL_DOUBLE_EN
    wait_cyc(1); check("dbl addr x0", addr1, 16'h1000);
    wait_cyc(2); check("dbl addr x1", addr1, 16'h1000);
    wait_cyc(3); check("dbl addr x2", addr1, 16'h1001);
    wait_cyc(4); check("dbl addr x3", addr1, 16'h1001);
    check_px("dbl px(3,0)", 3, 12'h001, 1'b1, 1'b1, 1'b0);
    check_px("dbl px(3,1)", 19, 12'h001, 1'b1, 1'b1, 1'b0);
    wait_cyc(33); check("dbl line2 addr", addr1, 16'h1004);
    check_px("dbl px(3,2)", 35, 12'h005, 1'b1, 1'b1, 1'b0);
`else
    // Frame 0/1, mode 0, base 0x1000: sync window h 10..12, v 5..6.
    add_vec(0,   12'h000, 1'b1, 1'b1, 1'b1, "px(0,0)");
    add_vec(3,   12'h003, 1'b1, 1'b1, 1'b0, "px(3,0)");
    add_vec(7,   12'h007, 1'b1, 1'b1, 1'b0, "px(7,0)");
    add_vec(10,  12'h000, 1'b0, 1'b1, 1'b0, "hs start");
    add_vec(13,  12'h000, 1'b1, 1'b1, 1'b0, "hs end");
    add_vec(16,  12'h008, 1'b1, 1'b1, 1'b0, "px(0,1)");
    add_vec(25,  12'h000, 1'b1, 1'b1, 1'b0, "h fp");
    add_vec(28,  12'h000, 1'b0, 1'b1, 1'b0, "hs last");
    add_vec(37,  12'h015, 1'b1, 1'b1, 1'b0, "px(5,2)");
    add_vec(62,  12'h000, 1'b1, 1'b1, 1'b0, "h bp");
    add_vec(64,  12'h000, 1'b1, 1'b1, 1'b0, "v fp");
    add_vec(80,  12'h000, 1'b1, 1'b0, 1'b0, "vs start");
    add_vec(106, 12'h000, 1'b0, 1'b0, 1'b0, "hs+vs");
    add_vec(112, 12'h000, 1'b1, 1'b1, 1'b0, "vs end");
    add_vec(128, 12'h000, 1'b1, 1'b1, 1'b1, "frame1 start");
    add_vec(130, 12'h002, 1'b1, 1'b1, 1'b0, "frame1 px(2,0)");
    for (int i = 0; i < vq.size(); i++)
      check_px(vq[i].name, vq[i].idx, vq[i].rgb, vq[i].hs, vq[i].vs, vq[i].fs);

    // Mid-frame base change only applies from the next frame.
    wait_cyc(148); base = 16'h8000;
    wait_cyc(162); check("addr keeps old base", addr1, 16'h1011);
    check_px("frame1 px(1,2)", 161, 12'h011, 1'b1, 1'b1, 1'b0);
    wait_cyc(257); check("frame2 addr0 ram_lat1", addr1, 16'h8000);
    check("frame2 addr0 ram_lat2", addr2, 16'h8000);
    wait_cyc(258); check("frame2 addr1", addr1, 16'h8001);
    check_px("frame2 px(2,0)", 258, 12'h002, 1'b1, 1'b1, 1'b0);
    wait_cyc(300); base = 16'hFFFF;
    wait_cyc(385); check("frame3 addr0", addr1, 16'hFFFF);
    wait_cyc(386); check("frame3 addr wrap", addr1, 16'h0000);
    check_px("frame3 px(2,0)", 386, 12'h001, 1'b1, 1'b1, 1'b0);

    // Palette mode: word 0x0050 holds nibbles 0,5,0,0.
    wait_cyc(400); base = 16'h0050; mode = 1'b1;
    check_seq4("pal line0", 512, 12'h0F5, 12'hF0A, 12'h0F5, 12'h0F5);
    check_px("pal px(1,1)", 529, 12'hF0A, 1'b1, 1'b1, 1'b0);
    // Write lands in the same cycle the RAM_LAT=1 DUT looks up px(5,1).
    wait_cyc(535); pal_we = 1'b1; pal_idx = 4'h5; pal_rgb = 12'h5A5;
    wait_cyc(536); pal_we = 1'b0;
    check("pal same-cycle write ram_lat1", pins1(), {1'b0, 12'hF0A, 1'b1, 1'b1, 1'b0});
    wait_cyc(537);
    check("pal after write ram_lat2", pins2(), {1'b0, 12'h5A5, 1'b1, 1'b1, 1'b0});
    check_px("pal px(1,2)", 545, 12'h5A5, 1'b1, 1'b1, 1'b0);

    // Now at raster index 549; assert clear for three edges.
    check("pre-clear px(2,2)", pins1(), {1'b0, 12'h0F5, 1'b1, 1'b1, 1'b0});
    clear = 1'b1;
    @(negedge clk);
    check("clear pins ram_lat1", pins1(), {1'b0, 12'h000, 1'b1, 1'b1, 1'b0});
    check("clear pins ram_lat2", pins2(), {1'b0, 12'h000, 1'b1, 1'b1, 1'b0});
    @(negedge clk);
    @(negedge clk);
    clear = 1'b0;
    wait_cyc(2);
    check("post-clear fs early", {15'h0, fs1}, 16'h0000);
    wait_cyc(3);
    check("post-clear fs ram_lat1", pins1(), {1'b0, 12'h0F5, 1'b1, 1'b1, 1'b1});
    check("post-clear fs early ram_lat2", {15'h0, fs2}, 16'h0000);
    wait_cyc(4);
    check("post-clear px1 ram_lat1", pins1(), {1'b0, 12'h5A5, 1'b1, 1'b1, 1'b0});
    check("post-clear fs ram_lat2", pins2(), {1'b0, 12'h0F5, 1'b1, 1'b1, 1'b1});
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
